semaforo_cruzamento: RTL

Parametrised two-road intersection controller with on-demand crossing. Road A (main) stays green until a button request is pending and its minimum green time has elapsed. Road B (side) then runs a full green/yellow cycle. Both roads get all-red clearance between phases. Timings and counter width are set by parameters.

---
 rtl/semaforo_cruzamento.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/semaforo_cruzamento.sv
// Two-road intersection controller: main road A stays green until a latched crossing request is served.
// Optional night flashing mode is enabled by defining SEMAFORO_NOTURNO_EN.
module semaforo_cruzamento #(
  parameter int CNT_W         = 8,
  parameter int T_VERDE_A_MIN = 20,
  parameter int T_AMARELO     = 5,
  parameter int T_VERMELHO    = 2,
  parameter int T_VERDE_B     = 15,
  parameter int T_PISCA       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bt,
  input  logic       noturno,
  output logic [2:0] A,
  output logic [2:0] B,
  output logic [2:0] estado,
  output logic       pedido_pendente
);

  typedef enum logic [2:0] {
    A_VERDE    = 3'd0,
    A_AMARELO  = 3'd1,
    VERMELHO_1 = 3'd2,
    B_VERDE    = 3'd3,
    B_AMARELO  = 3'd4,
    VERMELHO_2 = 3'd5,
    PISCA      = 3'd6
  } estado_t;

  localparam logic [CNT_W-1:0] FIM_VA = CNT_W'(T_VERDE_A_MIN - 1);
  localparam logic [CNT_W-1:0] FIM_AM = CNT_W'(T_AMARELO - 1);
  localparam logic [CNT_W-1:0] FIM_VM = CNT_W'(T_VERMELHO - 1);
  localparam logic [CNT_W-1:0] FIM_VB = CNT_W'(T_VERDE_B - 1);

  estado_t          est;
  logic [CNT_W-1:0] cnt;
  logic             bt_s1, bt_s2, bt_s3;
  logic             subida;

  // bt_s3 is a delayed copy of the synchronised level, used only for edge detection
  assign subida = bt_s2 & ~bt_s3;

`ifdef SEMAFORO_NOTURNO_EN
  localparam logic [CNT_W-1:0] FIM_PI = CNT_W'(T_PISCA - 1);
  logic n_s1, n_s2;
  logic fase;
`else
  localparam int unused_t_pisca = T_PISCA;
  logic unused_noturno;
  assign unused_noturno = noturno;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      est             <= A_VERDE;
      cnt             <= '0;
      bt_s1           <= 1'b0;
      bt_s2           <= 1'b0;
      bt_s3           <= 1'b0;
      pedido_pendente <= 1'b0;
`ifdef SEMAFORO_NOTURNO_EN
      n_s1            <= 1'b0;
      n_s2            <= 1'b0;
      fase            <= 1'b0;
`endif
    end else begin
      bt_s1           <= bt;
      bt_s2           <= bt_s1;
      bt_s3           <= bt_s2;
      cnt             <= cnt + 1'b1;
      pedido_pendente <= pedido_pendente | subida;
`ifdef SEMAFORO_NOTURNO_EN
      n_s1            <= noturno;
      n_s2            <= n_s1;
      if (n_s2 && est != PISCA) begin
        est             <= PISCA;
        cnt             <= '0;
        fase            <= 1'b0;
        pedido_pendente <= 1'b0;
      end else
`endif
      case (est)
        A_VERDE: begin
          // counter parks at the minimum-green mark until a request shows up
          if (cnt == FIM_VA) begin
            if (pedido_pendente) begin
              est <= A_AMARELO;
              cnt <= '0;
            end else begin
              cnt <= cnt;
            end
          end
        end
        A_AMARELO: if (cnt == FIM_AM) begin est <= VERMELHO_1; cnt <= '0; end
        VERMELHO_1: begin
          if (cnt == FIM_VM) begin
            est             <= B_VERDE;
            cnt             <= '0;
            pedido_pendente <= subida;
          end
        end
        B_VERDE:    if (cnt == FIM_VB) begin est <= B_AMARELO;  cnt <= '0; end
        B_AMARELO:  if (cnt == FIM_AM) begin est <= VERMELHO_2; cnt <= '0; end
        VERMELHO_2: if (cnt == FIM_VM) begin est <= A_VERDE;    cnt <= '0; end
`ifdef SEMAFORO_NOTURNO_EN
        PISCA: begin
          pedido_pendente <= 1'b0;
          if (!n_s2) begin
            est <= VERMELHO_2;
            cnt <= '0;
          end else if (cnt == FIM_PI) begin
            cnt  <= '0;
            fase <= ~fase;
          end
        end
`endif
        default: begin
          est <= VERMELHO_2;
          cnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    A = 3'b001;
    B = 3'b001;
    case (est)
      A_VERDE:   A = 3'b100;
      A_AMARELO: A = 3'b010;
      B_VERDE:   B = 3'b100;
      B_AMARELO: B = 3'b010;
`ifdef SEMAFORO_NOTURNO_EN
      PISCA: begin
        A = fase ? 3'b000 : 3'b010;
        B = fase ? 3'b000 : 3'b010;
      end
`endif
      default: ;
    endcase
  end

  assign estado = est;

endmodule
